// File: rtl/shutter_monitor.sv
// shutter_monitor: measures the high and low phase lengths of the beam and
// feedback gates. It also counts the number of completed periods of each gate.
// The results feed status registers, so software can compare the programmed
// on/off durations against the durations the shutter generator really produced.
// Optional feature macro: SHUTTER_MONITOR_FEEDBACK_EN builds the feedback channel.
// When the macro is not defined, the feedback outputs are tied to zero.

module shutter_monitor_channel #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             armed,
    input  logic             arm_rise,
    input  logic             gate_q,
    input  logic             gate_p,
    output logic [CNT_W-1:0] on_len,
    output logic [CNT_W-1:0] off_len,
    output logic [PER_W-1:0] periods,
    output logic             valid,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEASURE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_next;
    logic [CNT_W-1:0] run_cnt_inc;
    logic             rise;
    logic             fall;
    logic             latch_on;
    logic             latch_off;

    assign rise        = gate_q & ~gate_p;
    assign fall        = ~gate_q & gate_p;
    assign run_cnt_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;

    // Next-state logic: a disarm beats any edge, and the first edge after arming only starts timing
    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        latch_on     = 1'b0;
        latch_off    = 1'b0;
        case (state)
            IDLE: begin
                run_cnt_next = '0;
                if (armed) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (!armed) begin
                    state_next   = IDLE;
                    run_cnt_next = '0;
                end else if (rise || fall) begin
                    state_next   = MEASURE;
                    run_cnt_next = CNT_ONE;
                end else begin
                    run_cnt_next = run_cnt_inc;
                end
            end
            MEASURE: begin
                if (!armed) begin
                    state_next   = IDLE;
                    run_cnt_next = '0;
                end else if (fall) begin
                    latch_on     = 1'b1;
                    run_cnt_next = CNT_ONE;
                end else if (rise) begin
                    latch_off    = 1'b1;
                    run_cnt_next = CNT_ONE;
                end else begin
                    run_cnt_next = run_cnt_inc;
                end
            end
            default: begin
                state_next   = IDLE;
                run_cnt_next = '0;
            end
        endcase
    end

    // State, run counter and result registers; arming afresh clears the period count and overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            run_cnt <= '0;
            on_len  <= '0;
            off_len <= '0;
            periods <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
            valid   <= latch_on | latch_off;
            if (latch_on) begin
                on_len <= run_cnt;
            end
            if (latch_off) begin
                off_len <= run_cnt;
                periods <= periods + PER_ONE;
            end
            if (arm_rise) begin
                periods <= '0;
                ovf     <= 1'b0;
            end else if ((latch_on || latch_off) && (run_cnt == CNT_MAX)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

module shutter_monitor #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic signed [15:0] switch_i,
    input  logic               beam_i,
    input  logic               feedback_i,
    output logic [CNT_W-1:0]   beam_on_len_o,
    output logic [CNT_W-1:0]   beam_off_len_o,
    output logic [PER_W-1:0]   beam_periods_o,
    output logic               beam_valid_o,
    output logic               beam_ovf_o,
    output logic [CNT_W-1:0]   feedback_on_len_o,
    output logic [CNT_W-1:0]   feedback_off_len_o,
    output logic [PER_W-1:0]   feedback_periods_o,
    output logic               feedback_valid_o,
    output logic               feedback_ovf_o
);

    logic signed [15:0] switch_q;
    logic               beam_q;
    logic               beam_p;
    logic               armed;
    logic               armed_prev;
    logic               arm_rise;

    // Arming threshold matches the generator's switch threshold
    assign armed    = (switch_q > 16'sd8192);
    assign arm_rise = armed & ~armed_prev;

    // Input stage: register the switch and the beam gate, keep the previous beam level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            switch_q   <= '0;
            beam_q     <= 1'b0;
            beam_p     <= 1'b0;
            armed_prev <= 1'b0;
        end else begin
            switch_q   <= switch_i;
            beam_q     <= beam_i;
            beam_p     <= beam_q;
            armed_prev <= armed;
        end
    end

    shutter_monitor_channel #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_beam (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .armed    (armed),
        .arm_rise (arm_rise),
        .gate_q   (beam_q),
        .gate_p   (beam_p),
        .on_len   (beam_on_len_o),
        .off_len  (beam_off_len_o),
        .periods  (beam_periods_o),
        .valid    (beam_valid_o),
        .ovf      (beam_ovf_o)
    );

`ifdef SHUTTER_MONITOR_FEEDBACK_EN
    logic feedback_q;
    logic feedback_p;

    // Feedback gate input stage, same two-register arrangement as the beam gate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            feedback_q <= 1'b0;
            feedback_p <= 1'b0;
        end else begin
            feedback_q <= feedback_i;
            feedback_p <= feedback_q;
        end
    end

    shutter_monitor_channel #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_feedback (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .armed    (armed),
        .arm_rise (arm_rise),
        .gate_q   (feedback_q),
        .gate_p   (feedback_p),
        .on_len   (feedback_on_len_o),
        .off_len  (feedback_off_len_o),
        .periods  (feedback_periods_o),
        .valid    (feedback_valid_o),
        .ovf      (feedback_ovf_o)
    );
`else
    logic feedback_unused;

    assign feedback_unused    = feedback_i;
    assign feedback_on_len_o  = '0;
    assign feedback_off_len_o = '0;
    assign feedback_periods_o = '0;
    assign feedback_valid_o   = 1'b0;
    assign feedback_ovf_o     = 1'b0;
`endif

endmodule

// File: tb/tb_shutter_monitor.sv
// tb_shutter_monitor: directed vector table plus randomized gate waveforms.
// The bench checks a full-width instance and a narrow instance. The narrow
// instance uses 4-bit counters, so phase saturation and period wrap are reached quickly.
// Expected values come from a timestamp-based reference model: a phase length is the
// distance between consecutive detected edges.

module tb_shutter_monitor;

    localparam int CNT_W     = 32;
    localparam int PER_W     = 16;
    localparam int SAT_CNT_W = 4;
    localparam int SAT_PER_W = 4;

`ifdef SHUTTER_MONITOR_FEEDBACK_EN
    localparam bit FB_EN = 1'b1;
`else
    localparam bit FB_EN = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [15:0] switch_i = '0;
    logic               beam_i = 1'b0;
    logic               feedback_i = 1'b0;

    logic [CNT_W-1:0]     beam_on_len_o, beam_off_len_o, feedback_on_len_o, feedback_off_len_o;
    logic [PER_W-1:0]     beam_periods_o, feedback_periods_o;
    logic                 beam_valid_o, beam_ovf_o, feedback_valid_o, feedback_ovf_o;
    logic [SAT_CNT_W-1:0] s_beam_on, s_beam_off, s_fb_on, s_fb_off;
    logic [SAT_PER_W-1:0] s_beam_per, s_fb_per;
    logic                 s_beam_val, s_beam_ovf, s_fb_val, s_fb_ovf;

    int checks = 0;
    int failures = 0;
    int valid_count = 0;

    // Reference model state: index 0/1 = full-width beam/feedback, 2/3 = narrow beam/feedback
    longint             m_on [4];
    longint             m_off [4];
    longint             m_per [4];
    longint             m_last [4];
    bit                 m_val [4];
    bit                 m_ovf [4];
    bit                 m_q [4];
    bit                 m_p [4];
    longint             m_max [4];
    longint             m_per_mod [4];
    logic signed [15:0] m_sw_q;
    bit                 m_armed_prev;
    longint             m_t;

    typedef struct {
        bit                 rst;
        logic signed [15:0] sw;
        bit                 beam;
        int                 n;
        int                 exp_on;
        int                 exp_off;
        int                 exp_per;
        int                 exp_valids;
    } vec_t;

    vec_t tbl [16];

    always #5 clk_i = ~clk_i;

    shutter_monitor #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .switch_i           (switch_i),
        .beam_i             (beam_i),
        .feedback_i         (feedback_i),
        .beam_on_len_o      (beam_on_len_o),
        .beam_off_len_o     (beam_off_len_o),
        .beam_periods_o     (beam_periods_o),
        .beam_valid_o       (beam_valid_o),
        .beam_ovf_o         (beam_ovf_o),
        .feedback_on_len_o  (feedback_on_len_o),
        .feedback_off_len_o (feedback_off_len_o),
        .feedback_periods_o (feedback_periods_o),
        .feedback_valid_o   (feedback_valid_o),
        .feedback_ovf_o     (feedback_ovf_o)
    );

    shutter_monitor #(.CNT_W(SAT_CNT_W), .PER_W(SAT_PER_W)) dut_sat (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .switch_i           (switch_i),
        .beam_i             (beam_i),
        .feedback_i         (feedback_i),
        .beam_on_len_o      (s_beam_on),
        .beam_off_len_o     (s_beam_off),
        .beam_periods_o     (s_beam_per),
        .beam_valid_o       (s_beam_val),
        .beam_ovf_o         (s_beam_ovf),
        .feedback_on_len_o  (s_fb_on),
        .feedback_off_len_o (s_fb_off),
        .feedback_periods_o (s_fb_per),
        .feedback_valid_o   (s_fb_val),
        .feedback_ovf_o     (s_fb_ovf)
    );

    function automatic void model_chan(input int i, input bit rst, input bit armed,
                                       input bit arm_rise, input bit gate_in);
        longint len;
        if (rst) begin
            m_on[i] = 0; m_off[i] = 0; m_per[i] = 0; m_val[i] = 0; m_ovf[i] = 0;
            m_last[i] = -1; m_q[i] = 0; m_p[i] = 0;
            return;
        end
        m_val[i] = 0;
        if (arm_rise) begin
            m_per[i] = 0; m_ovf[i] = 0; m_last[i] = -1;
        end else if (!armed) begin
            m_last[i] = -1;
        end else if (m_q[i] != m_p[i]) begin
            if (m_last[i] >= 0) begin
                len = m_t - m_last[i];
                if (len > m_max[i]) len = m_max[i];
                if (m_q[i] == 1'b0) begin
                    m_on[i] = len;
                end else begin
                    m_off[i] = len;
                    m_per[i] = (m_per[i] + 1) % m_per_mod[i];
                end
                m_val[i] = 1;
                if (len == m_max[i]) m_ovf[i] = 1;
            end
            m_last[i] = m_t;
        end
        m_p[i] = m_q[i];
        m_q[i] = gate_in;
    endfunction

    function automatic void model_step(input bit rst, input logic signed [15:0] sw,
                                       input bit beam, input bit fb);
        bit armed;
        bit arm_rise;
        armed    = (m_sw_q > 16'sd8192);
        arm_rise = armed && !m_armed_prev;
        for (int i = 0; i < 4; i++) begin
            model_chan(i, rst, armed, arm_rise, (i % 2 == 0) ? beam : fb);
        end
        if (rst) begin
            m_sw_q = '0; m_armed_prev = 0;
        end else begin
            m_sw_q = sw; m_armed_prev = armed;
        end
        m_t++;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all();
        checkOutput("beam_on_len", longint'(beam_on_len_o), m_on[0]);
        checkOutput("beam_off_len", longint'(beam_off_len_o), m_off[0]);
        checkOutput("beam_periods", longint'(beam_periods_o), m_per[0]);
        checkOutput("beam_valid", longint'(beam_valid_o), longint'(m_val[0]));
        checkOutput("beam_ovf", longint'(beam_ovf_o), longint'(m_ovf[0]));
        checkOutput("fb_on_len", longint'(feedback_on_len_o), FB_EN ? m_on[1] : 0);
        checkOutput("fb_off_len", longint'(feedback_off_len_o), FB_EN ? m_off[1] : 0);
        checkOutput("fb_periods", longint'(feedback_periods_o), FB_EN ? m_per[1] : 0);
        checkOutput("fb_valid", longint'(feedback_valid_o), FB_EN ? longint'(m_val[1]) : 0);
        checkOutput("fb_ovf", longint'(feedback_ovf_o), FB_EN ? longint'(m_ovf[1]) : 0);
        checkOutput("sat_beam_on_len", longint'(s_beam_on), m_on[2]);
        checkOutput("sat_beam_off_len", longint'(s_beam_off), m_off[2]);
        checkOutput("sat_beam_periods", longint'(s_beam_per), m_per[2]);
        checkOutput("sat_beam_valid", longint'(s_beam_val), longint'(m_val[2]));
        checkOutput("sat_beam_ovf", longint'(s_beam_ovf), longint'(m_ovf[2]));
        checkOutput("sat_fb_on_len", longint'(s_fb_on), FB_EN ? m_on[3] : 0);
        checkOutput("sat_fb_off_len", longint'(s_fb_off), FB_EN ? m_off[3] : 0);
        checkOutput("sat_fb_periods", longint'(s_fb_per), FB_EN ? m_per[3] : 0);
        checkOutput("sat_fb_valid", longint'(s_fb_val), FB_EN ? longint'(m_val[3]) : 0);
        checkOutput("sat_fb_ovf", longint'(s_fb_ovf), FB_EN ? longint'(m_ovf[3]) : 0);
    endtask

    task automatic stepCycle(input bit rst, input logic signed [15:0] sw, input bit beam, input bit fb);
        @(negedge clk_i);
        rst_i      = rst;
        switch_i   = sw;
        beam_i     = beam;
        feedback_i = fb;
        @(posedge clk_i);
        model_step(rst, sw, beam, fb);
        #1;
        check_all();
        if (beam_valid_o) valid_count++;
    endtask

    task automatic applyStimulus(input bit rst, input logic signed [15:0] sw, input bit beam,
                                 input bit fb, input int n);
        for (int k = 0; k < n; k++) begin
            stepCycle(rst, sw, beam, fb);
        end
    endtask

    initial begin
        logic signed [15:0] sw_choices [7];
        logic signed [15:0] cur_sw;
        int  b_left;
        int  f_left;
        bit  b_lvl;
        bit  f_lvl;
        bit  rnd_rst;

        sw_choices = '{16'sd0, 16'sd8192, 16'sd8193, 16'sd9000, 16'sh8000, 16'sd32767, 16'sd12000};
        m_max      = '{64'd4294967295, 64'd4294967295, 64'd15, 64'd15};
        m_per_mod  = '{64'd65536, 64'd65536, 64'd16, 64'd16};
        for (int i = 0; i < 4; i++) model_chan(i, 1'b1, 1'b0, 1'b0, 1'b0);
        m_sw_q = '0; m_armed_prev = 0; m_t = 0;

        // rst, sw, beam, cycles, expected on/off/periods, beam valid strobes within the row
        tbl[0]  = '{1'b1, 16'sd0,    1'b0, 2, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 16'sd9000, 1'b0, 4, 0, 0, 0, 0};
        tbl[2]  = '{1'b0, 16'sd9000, 1'b1, 5, 0, 0, 0, 0};
        tbl[3]  = '{1'b0, 16'sd9000, 1'b0, 3, 5, 0, 0, 1};
        tbl[4]  = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 1, 1};
        tbl[5]  = '{1'b0, 16'sd9000, 1'b0, 3, 5, 3, 1, 1};
        tbl[6]  = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 2, 1};
        tbl[7]  = '{1'b0, 16'sd9000, 1'b0, 3, 5, 3, 2, 1};
        tbl[8]  = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 3, 1};
        tbl[9]  = '{1'b0, 16'sd9000, 1'b0, 3, 5, 3, 3, 1};
        tbl[10] = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 4, 1};
        tbl[11] = '{1'b0, 16'sd0,    1'b0, 4, 5, 3, 4, 0};
        tbl[12] = '{1'b0, 16'sd9000, 1'b0, 3, 5, 3, 0, 0};
        tbl[13] = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 0, 0};
        tbl[14] = '{1'b0, 16'sd9000, 1'b0, 3, 5, 3, 0, 1};
        tbl[15] = '{1'b0, 16'sd9000, 1'b1, 5, 5, 3, 1, 1};

        $display("[TB] table-driven arm, measure, disarm and re-arm");
        for (int r = 0; r < 16; r++) begin
            valid_count = 0;
            applyStimulus(tbl[r].rst, tbl[r].sw, tbl[r].beam, 1'b0, tbl[r].n);
            checkOutput($sformatf("row%0d_on", r), longint'(beam_on_len_o), longint'(tbl[r].exp_on));
            checkOutput($sformatf("row%0d_off", r), longint'(beam_off_len_o), longint'(tbl[r].exp_off));
            checkOutput($sformatf("row%0d_periods", r), longint'(beam_periods_o), longint'(tbl[r].exp_per));
            checkOutput($sformatf("row%0d_valids", r), longint'(valid_count), longint'(tbl[r].exp_valids));
        end

        $display("[TB] threshold boundary");
        applyStimulus(1'b1, 16'sd0, 1'b0, 1'b0, 2);
        valid_count = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 16'sd8192, 1'b1, 1'b0, 2);
            applyStimulus(1'b0, 16'sd8192, 1'b0, 1'b0, 2);
        end
        checkOutput("thr8192_valids", longint'(valid_count), 0);
        checkOutput("thr8192_periods", longint'(beam_periods_o), 0);
        valid_count = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 16'sd8193, 1'b1, 1'b0, 2);
            applyStimulus(1'b0, 16'sd8193, 1'b0, 1'b0, 2);
        end
        checkOutput("thr8193_started", longint'(valid_count > 0), 1);
        checkOutput("thr8193_on", longint'(beam_on_len_o), 2);
        checkOutput("thr8193_off", longint'(beam_off_len_o), 2);
        valid_count = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 16'sh8000, 1'b1, 1'b0, 2);
            applyStimulus(1'b0, 16'sh8000, 1'b0, 1'b0, 2);
        end
        checkOutput("thr_neg_valids", longint'(valid_count), 0);

        $display("[TB] saturation on the narrow instance");
        applyStimulus(1'b1, 16'sd0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 16'sd9000, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 16'sd9000, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 16'sd9000, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 16'sd9000, 1'b1, 1'b0, 3);
        checkOutput("sat_off_len", longint'(s_beam_off), 15);
        checkOutput("sat_ovf", longint'(s_beam_ovf), 1);
        checkOutput("sat_on_len", longint'(s_beam_on), 3);
        checkOutput("wide_off_len", longint'(beam_off_len_o), 20);
        checkOutput("wide_ovf", longint'(beam_ovf_o), 0);
        applyStimulus(1'b0, 16'sd9000, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 16'sd9000, 1'b1, 1'b0, 3);
        checkOutput("sat_ovf_sticky", longint'(s_beam_ovf), 1);
        checkOutput("sat_off_short", longint'(s_beam_off), 3);
        applyStimulus(1'b0, 16'sd0, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 16'sd9000, 1'b1, 1'b0, 3);
        checkOutput("sat_ovf_rearm", longint'(s_beam_ovf), 0);
        checkOutput("sat_periods_rearm", longint'(s_beam_per), 0);

        $display("[TB] channel independence and mid-run reset");
        applyStimulus(1'b1, 16'sd0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 16'sd9000, 1'b0, 1'b0, 3);
        for (int k = 0; k < 80; k++) begin
            stepCycle(1'b0, 16'sd9000, (k % 8) < 5, (k % 9) < 2);
        end
        checkOutput("ind_beam_on", longint'(beam_on_len_o), 5);
        checkOutput("ind_beam_off", longint'(beam_off_len_o), 3);
        checkOutput("ind_fb_on", longint'(feedback_on_len_o), FB_EN ? 2 : 0);
        checkOutput("ind_fb_off", longint'(feedback_off_len_o), FB_EN ? 7 : 0);
        stepCycle(1'b1, 16'sd9000, 1'b1, 1'b1);
        checkOutput("rst_beam_on", longint'(beam_on_len_o), 0);
        checkOutput("rst_beam_off", longint'(beam_off_len_o), 0);
        checkOutput("rst_beam_periods", longint'(beam_periods_o), 0);
        checkOutput("rst_fb_on", longint'(feedback_on_len_o), 0);
        checkOutput("rst_fb_off", longint'(feedback_off_len_o), 0);

        $display("[TB] randomized gates against the reference model");
        cur_sw = 16'sd9000;
        b_left = 0; f_left = 0; b_lvl = 0; f_lvl = 0;
        for (int k = 0; k < 3000; k++) begin
            if (b_left <= 0) begin
                b_lvl  = !b_lvl;
                b_left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 24)) : int'($urandom_range(1, 6));
            end
            if (f_left <= 0) begin
                f_lvl  = !f_lvl;
                f_left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 24)) : int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 149) == 0) cur_sw = sw_choices[$urandom_range(0, 6)];
            rnd_rst = ($urandom_range(0, 599) == 0);
            stepCycle(rnd_rst, cur_sw, b_lvl, f_lvl);
            b_left--;
            f_left--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
